gen12_framing_parser: RTL and testbench

GEN12_FRAMING_PARSER -- requirements
Module: gen12_framing_parser

---
 rtl/gen12_framing_parser_pkg.sv | 18 +
 rtl/gen12_lane_classifier.sv | 82 ++++++++
 rtl/gen12_framing_parser.sv | 85 ++++++++
 tb/tb_gen12_framing_parser.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/gen12_framing_parser_pkg.sv
// Shared symbol constants, parser state encoding and DLLP length for the
// Gen1/2 framing parser.
package gen12_framing_parser_pkg;

  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] SDP = 8'h5C;
  localparam logic [7:0] END = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE;

  localparam logic [2:0] DLLP_LEN = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IN_TLP  = 2'd1,
    ST_IN_DLLP = 2'd2
  } pkt_state_e;

endpackage

// File: rtl/gen12_lane_classifier.sv
// Per-lane framing classifier: takes the state and DLLP count left by the
// previous lane and produces this lane's flags plus the state for the next.
//
// state      | meaning
// ST_IDLE    | between packets, only STP/SDP are acted on
// ST_IN_TLP  | inside a TLP, waiting for END or EDB
// ST_IN_DLLP | inside a DLLP, counting D-symbols up to DLLP_LEN
module gen12_lane_classifier
  import gen12_framing_parser_pkg::*;
(
  input  pkt_state_e  i_state,
  input  logic [2:0]  i_cnt,
  input  logic [7:0]  i_data,
  input  logic        i_dk,
  input  logic        i_valid,
  output pkt_state_e  o_state,
  output logic [2:0]  o_cnt,
  output logic        o_tlp_start,
  output logic        o_tlp_end,
  output logic        o_tlp_edb,
  output logic        o_dllp_start,
  output logic        o_dllp_end,
  output logic        o_frm_err
);

  logic w_is_stp;
  logic w_is_sdp;

  assign w_is_stp = i_dk && (i_data == STP);
  assign w_is_sdp = i_dk && (i_data == SDP);

  // Next-state and flag decode for one symbol
  always_comb begin
    o_state      = i_state;
    o_cnt        = i_cnt;
    o_tlp_start  = 1'b0;
    o_tlp_end    = 1'b0;
    o_tlp_edb    = 1'b0;
    o_dllp_start = 1'b0;
    o_dllp_end   = 1'b0;
    o_frm_err    = 1'b0;
    if (i_valid) begin
      // A start symbol opens a packet from any state; outside IDLE it also
      // aborts the open packet with an error on the same lane.
      if (w_is_stp) begin
        o_frm_err   = (i_state != ST_IDLE);
        o_tlp_start = 1'b1;
        o_state     = ST_IN_TLP;
      end else if (w_is_sdp) begin
        o_frm_err    = (i_state != ST_IDLE);
        o_dllp_start = 1'b1;
        o_cnt        = 3'd0;
        o_state      = ST_IN_DLLP;
      end else begin
        unique case (i_state)
          ST_IN_TLP: begin
            if (i_dk) begin
              o_state = ST_IDLE;
              if (i_data == END)      o_tlp_end = 1'b1;
              else if (i_data == EDB) o_tlp_edb = 1'b1;
              else                    o_frm_err = 1'b1;
            end
          end
          ST_IN_DLLP: begin
            if (i_dk) begin
              o_state = ST_IDLE;
              if ((i_data == END) && (i_cnt == DLLP_LEN)) o_dllp_end = 1'b1;
              else                                        o_frm_err  = 1'b1;
            end else if (i_cnt == DLLP_LEN) begin
              o_frm_err = 1'b1;
              o_state   = ST_IDLE;
            end else begin
              o_cnt = i_cnt + 3'd1;
            end
          end
          default: o_state = ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/gen12_framing_parser.sv
// Gen1/2 framing parser: chains one classifier per byte lane and registers
// the flags, delayed data and the end-of-cycle parser state.
module gen12_framing_parser
  import gen12_framing_parser_pkg::*;
#(
  parameter int LANES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [8*LANES-1:0] data_in,
  input  logic [LANES-1:0]   dk_in,
  input  logic [LANES-1:0]   valid_in,
  output logic [8*LANES-1:0] data_out,
  output logic [LANES-1:0]   valid_out,
  output logic [LANES-1:0]   tlp_start,
  output logic [LANES-1:0]   tlp_end,
  output logic [LANES-1:0]   tlp_edb,
  output logic [LANES-1:0]   dllp_start,
  output logic [LANES-1:0]   dllp_end,
  output logic [LANES-1:0]   frm_err,
  output logic [1:0]         pkt_state
);

  pkt_state_e       r_state;
  logic [2:0]       r_cnt;
  logic [LANES-1:0] w_tlp_start, w_tlp_end, w_tlp_edb;
  logic [LANES-1:0] w_dllp_start, w_dllp_end, w_frm_err;

  for (genvar gi = 0; gi < LANES; gi++) begin : gen_lane
    pkt_state_e w_st_in, w_st_out;
    logic [2:0] w_cnt_in, w_cnt_out;
    if (gi == 0) begin : gen_head
      assign w_st_in  = r_state;
      assign w_cnt_in = r_cnt;
    end else begin : gen_link
      assign w_st_in  = gen_lane[gi-1].w_st_out;
      assign w_cnt_in = gen_lane[gi-1].w_cnt_out;
    end
    gen12_lane_classifier u_lane (
      .i_state      (w_st_in),
      .i_cnt        (w_cnt_in),
      .i_data       (data_in[8*gi +: 8]),
      .i_dk         (dk_in[gi]),
      .i_valid      (valid_in[gi]),
      .o_state      (w_st_out),
      .o_cnt        (w_cnt_out),
      .o_tlp_start  (w_tlp_start[gi]),
      .o_tlp_end    (w_tlp_end[gi]),
      .o_tlp_edb    (w_tlp_edb[gi]),
      .o_dllp_start (w_dllp_start[gi]),
      .o_dllp_end   (w_dllp_end[gi]),
      .o_frm_err    (w_frm_err[gi])
    );
  end

  // Register flags, delayed data and the state carried into the next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      data_out   <= '0;
      valid_out  <= '0;
      tlp_start  <= '0;
      tlp_end    <= '0;
      tlp_edb    <= '0;
      dllp_start <= '0;
      dllp_end   <= '0;
      frm_err    <= '0;
    end else begin
      r_state    <= gen_lane[LANES-1].w_st_out;
      r_cnt      <= gen_lane[LANES-1].w_cnt_out;
      data_out   <= data_in;
      valid_out  <= valid_in;
      tlp_start  <= w_tlp_start;
      tlp_end    <= w_tlp_end;
      tlp_edb    <= w_tlp_edb;
      dllp_start <= w_dllp_start;
      dllp_end   <= w_dllp_end;
      frm_err    <= w_frm_err;
    end
  end

  assign pkt_state = r_state;

endmodule

// File: tb/tb_gen12_framing_parser.sv
// Directed bench for the framing parser: an 8-lane and a 4-lane instance
// driven with hand-built symbol vectors and hand-computed expected flags.
module tb_gen12_framing_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [63:0] d8 = '0;
  logic [7:0]  k8 = '0, v8 = '0;
  logic [63:0] do8;
  logic [7:0]  vo8, ts8, te8, edb8, ds8, de8, er8;
  logic [1:0]  st8;

  logic [31:0] d4 = '0;
  logic [3:0]  k4 = '0, v4 = '0;
  logic [31:0] do4;
  logic [3:0]  vo4, ts4, te4, edb4, ds4, de4, er4;
  logic [1:0]  st4;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  gen12_framing_parser #(.LANES(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .data_in(d8), .dk_in(k8), .valid_in(v8),
    .data_out(do8), .valid_out(vo8), .tlp_start(ts8), .tlp_end(te8),
    .tlp_edb(edb8), .dllp_start(ds8), .dllp_end(de8), .frm_err(er8),
    .pkt_state(st8)
  );

  gen12_framing_parser #(.LANES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .data_in(d4), .dk_in(k4), .valid_in(v4),
    .data_out(do4), .valid_out(vo4), .tlp_start(ts4), .tlp_end(te4),
    .tlp_edb(edb4), .dllp_start(ds4), .dllp_end(de4), .frm_err(er4),
    .pkt_state(st4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] ts, input logic [7:0] te,
                      input logic [7:0] edb, input logic [7:0] ds, input logic [7:0] de,
                      input logic [7:0] er, input logic [1:0] st);
    chk({tag, ".tlp_start"},  64'(ts8),  64'(ts));
    chk({tag, ".tlp_end"},    64'(te8),  64'(te));
    chk({tag, ".tlp_edb"},    64'(edb8), 64'(edb));
    chk({tag, ".dllp_start"}, 64'(ds8),  64'(ds));
    chk({tag, ".dllp_end"},   64'(de8),  64'(de));
    chk({tag, ".frm_err"},    64'(er8),  64'(er));
    chk({tag, ".pkt_state"},  64'(st8),  64'(st));
  endtask

  task automatic chk4(input string tag, input logic [3:0] ts, input logic [3:0] te,
                      input logic [3:0] edb, input logic [3:0] ds, input logic [3:0] de,
                      input logic [3:0] er, input logic [1:0] st);
    chk({tag, ".tlp_start"},  64'(ts4),  64'(ts));
    chk({tag, ".tlp_end"},    64'(te4),  64'(te));
    chk({tag, ".tlp_edb"},    64'(edb4), 64'(edb));
    chk({tag, ".dllp_start"}, 64'(ds4),  64'(ds));
    chk({tag, ".dllp_end"},   64'(de4),  64'(de));
    chk({tag, ".frm_err"},    64'(er4),  64'(er));
    chk({tag, ".pkt_state"},  64'(st4),  64'(st));
  endtask

  // Apply the current inputs for one clock and sample 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pk8(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
    return {b7, b6, b5, b4, b3, b2, b1, b0};
  endfunction

  function automatic logic [31:0] pk4(input logic [7:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  initial begin
    // Reset state
    step();
    step();
    chk8("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
    chk("reset.valid_out", 64'(vo8), 64'h0);
    chk("reset.data_out", do8, 64'h0);
    chk4("reset4", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
    rst_n = 1'b1;
    step();

    // STP, 3 D, END in lanes 0-4
    d8 = pk8(8'hFB, 8'h11, 8'h22, 8'h33, 8'hFD, 8'h00, 8'h00, 8'h00);
    k8 = 8'h11; v8 = 8'h1F;
    step();
    chk8("tlp_basic", 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
    chk("tlp_basic.data_out", do8, 64'h0000_00FD_3322_11FB);
    chk("tlp_basic.valid_out", 64'(vo8), 64'h1F);

    // SDP + 5 D + END: short DLLP
    d8 = pk8(8'h5C, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hFD, 8'h00);
    k8 = 8'h41; v8 = 8'h7F;
    step();
    chk8("dllp_short", 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h40, 2'd0);

    // SDP + 7 D: the 7th D-symbol is an error
    d8 = pk8(8'h5C, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07);
    k8 = 8'h01; v8 = 8'hFF;
    step();
    chk8("dllp_long", 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h80, 2'd0);

    // SDP then EDB inside a DLLP
    d8 = pk8(8'h5C, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    k8 = 8'h03; v8 = 8'h03;
    step();
    chk8("dllp_edb", 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 2'd0);

    // STP, D, STP: abort and restart in the same lane
    d8 = pk8(8'hFB, 8'hAA, 8'hFB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    k8 = 8'h05; v8 = 8'h07;
    step();
    chk8("stp_restart", 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 2'd1);

    // Close the open TLP in lane 0 of the next cycle
    d8 = pk8(8'hFD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    k8 = 8'h01; v8 = 8'h01;
    step();
    chk8("tlp_close", 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);

    // STP, invalid lanes 1-3 carrying END K-symbols, EDB in lane 4
    d8 = pk8(8'hFB, 8'hFD, 8'hFD, 8'hFD, 8'hFE, 8'h00, 8'h00, 8'h00);
    k8 = 8'h1F; v8 = 8'h11;
    step();
    chk8("edb_gap", 8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 2'd0);

    // TLP spanning cycles: STP in lane 7, END in lane 2 next cycle
    d8 = pk8(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFB);
    k8 = 8'h80; v8 = 8'h80;
    step();
    chk8("span_a", 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'd1);
    d8 = pk8(8'h10, 8'h20, 8'hFD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    k8 = 8'h04; v8 = 8'h07;
    step();
    chk8("span_b", 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);

    // Reset in the middle of a TLP
    d8 = pk8(8'hFB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    k8 = 8'h01; v8 = 8'h01;
    step();
    chk8("pre_rst", 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'd1);
    #2 rst_n = 1'b0;
    #1;
    chk8("in_rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
    chk("in_rst.valid_out", 64'(vo8), 64'h0);
    d8 = pk8(8'h01, 8'h02, 8'h03, 8'hFD, 8'h00, 8'h00, 8'h00, 8'h00);
    k8 = 8'h08; v8 = 8'h0F;
    step();
    chk("in_rst_edge.tlp_start", 64'(ts8), 64'h0);
    rst_n = 1'b1;
    step();
    chk8("post_rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
    chk("post_rst.valid_out", 64'(vo8), 64'h0F);
    v8 = 8'h00; k8 = 8'h00;

    // DLLP spanning two 4-lane cycles
    d4 = pk4(8'h5C, 8'h01, 8'h02, 8'h03);
    k4 = 4'h1; v4 = 4'hF;
    step();
    chk4("dllp_span_a", 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 2'd2);
    d4 = pk4(8'h04, 8'h05, 8'h06, 8'hFD);
    k4 = 4'h8; v4 = 4'hF;
    step();
    chk4("dllp_span_b", 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 2'd0);
    chk("dllp_span_b.data_out", 64'(do4), 64'hFD06_0504);

    // SDP interrupting a 4-lane TLP
    d4 = pk4(8'hFB, 8'h01, 8'h5C, 8'h02);
    k4 = 4'h5; v4 = 4'hF;
    step();
    chk4("sdp_abort", 4'h1, 4'h0, 4'h0, 4'h4, 4'h0, 4'h4, 2'd2);
    v4 = 4'h0;
    step();
    chk4("idle_hold", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
